// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite responder fronting a NUM_REGS x DATA_WIDTH register bank
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   aw_* / w_* / b_*                 AXI-Lite write address, data and response channels
//   ar_* / r_*                       AXI-Lite read address and data channels
//   reg_q_o                          flat register contents, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o                       one-cycle pulse per register written with any strobe set
//
// Build option: define AXI_LITE_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR
// instead of silently dropping them with OKAY.
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
    input  logic                           aw_valid_i,
    output logic                           aw_ready_o,
    input  logic [DATA_WIDTH-1:0]          w_data_i,
    input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    output logic [1:0]                     b_resp_o,
    output logic                           b_valid_o,
    input  logic                           b_ready_i,
    input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
    input  logic                           ar_valid_i,
    output logic                           ar_ready_o,
    output logic [DATA_WIDTH-1:0]          r_data_o,
    output logic [1:0]                     r_resp_o,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(SW);
    localparam int IW  = $clog2(NUM_REGS);
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_LITE_REGFILE_SLVERR_EN
    localparam logic [1:0] BAD_RESP = 2'b10;
`else
    localparam logic [1:0] BAD_RESP = 2'b00;
`endif

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [SW-1:0]         w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_in, rd_in;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [SW-1:0]         wr_strb;
    logic [IW-1:0]         wr_idx, rd_idx;

    assign aw_ready_o = !aw_held && !b_valid_o;
    assign w_ready_o  = !w_held && !b_valid_o;
    assign ar_ready_o = !r_valid_o;

    assign aw_hs  = aw_valid_i && aw_ready_o;
    assign w_hs   = w_valid_i && w_ready_o;
    assign ar_hs  = ar_valid_i && ar_ready_o;
    // Either half may already be parked or arriving right now; commit once both are present.
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr = aw_held ? aw_addr_q : aw_addr_i;
    assign wr_data = w_held ? w_data_q : w_data_i;
    assign wr_strb = w_held ? w_strb_q : w_strb_i;
    assign wr_in   = (wr_addr >> OFS) < ADDR_WIDTH'(NUM_REGS);
    assign wr_idx  = wr_addr[OFS +: IW];
    assign rd_in   = (ar_addr_i >> OFS) < ADDR_WIDTH'(NUM_REGS);
    assign rd_idx  = ar_addr_i[OFS +: IW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_o  <= 1'b0;
            b_resp_o   <= OKAY;
            wr_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse_o <= (commit && wr_in && |wr_strb) ? NUM_REGS'(1) << wr_idx : '0;
            if (b_valid_o && b_ready_i) b_valid_o <= 1'b0;
            if (commit) begin
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                b_valid_o <= 1'b1;
                b_resp_o  <= wr_in ? OKAY : BAD_RESP;
                if (wr_in)
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= aw_addr_i;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= w_data_i;
                    w_strb_q <= w_strb_i;
                end
            end
        end
    end

    // Reads sample the bank before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_resp_o  <= OKAY;
        end else if (ar_hs) begin
            r_valid_o <= 1'b1;
            r_data_o  <= rd_in ? regs[rd_idx] : '0;
            r_resp_o  <= rd_in ? OKAY : BAD_RESP;
        end else if (r_valid_o && r_ready_i) begin
            r_valid_o <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_exp
        assign reg_q_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb_axi_lite_regfile_slave: directed table-driven bench for axi_lite_regfile_slave
module tb_axi_lite_regfile_slave;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [3:0]   w_strb = '0;
    logic         aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
    logic         b_ready = 1'b1, r_ready = 1'b1;
    logic         aw_ready, w_ready, ar_ready, b_valid, r_valid;
    logic [1:0]   b_resp, r_resp;
    logic [31:0]  r_data;
    logic [255:0] reg_q;
    logic [7:0]   wr_pulse;

    int n_vec = 0;
    int n_bad = 0;

`ifdef AXI_LITE_REGFILE_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs[12];

    axi_lite_regfile_slave dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .reg_q_o(reg_q), .wr_pulse_o(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [7:0] pulse);
        @(negedge clk);
        aw_addr = a; aw_valid = 1'b1; w_data = d; w_strb = s; w_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        check("bvalid_latency", b_valid, 1'b1);
        resp = b_resp; pulse = wr_pulse;
        @(posedge clk); #1;
        check("bvalid_clear", b_valid, 1'b0);
        check("pulse_one_cycle", wr_pulse, 8'h00);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        @(negedge clk);
        ar_addr = a; ar_valid = 1'b1;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check("rvalid_latency", r_valid, 1'b1);
        d = r_data; resp = r_resp;
        @(posedge clk); #1;
        check("rvalid_clear", r_valid, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 8'h02};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 8'h00};
        vecs[2]  = '{1'b1, 32'h05, 32'h000000AA, 4'h1, 32'h0,        2'b00, 8'h02};
        vecs[3]  = '{1'b0, 32'h07, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00, 8'h00};
        vecs[4]  = '{1'b1, 32'h1C, 32'h12345678, 4'hC, 32'h0,        2'b00, 8'h80};
        vecs[5]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'h12340000, 2'b00, 8'h00};
        vecs[6]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 8'h00};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h00000000, 2'b00, 8'h00};
        vecs[8]  = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0,        ERR,   8'h00};
        vecs[9]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h00000000, ERR,   8'h00};
        vecs[10] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00, 8'h00};
        vecs[11] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h00000000, 2'b00, 8'h00};

        // Reset, then reset again while a write address is parked
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); aw_addr = 32'h4; aw_valid = 1'b1;
        @(posedge clk); #1; aw_valid = 1'b0;
        check("aw_held", aw_ready, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_aw_ready", aw_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        check("rst_w_ready", w_ready, 1'b1);
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_resp", {b_resp, r_resp}, 4'h0);
        check("rst_r_data", r_data, 32'h0);
        check("rst_reg_q", |reg_q, 1'b0);
        check("rst_pulse", wr_pulse, 8'h00);
        @(negedge clk); w_data = 32'h0; w_strb = 4'h0; w_valid = 1'b1;
        @(posedge clk); #1; w_valid = 1'b0;
        check("no_commit_after_rst", b_valid, 1'b0);
        @(posedge clk); #1;
        check("no_commit_after_rst2", b_valid, 1'b0);
        check("w_parked", w_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // W three cycles ahead of AW
        @(negedge clk); w_data = 32'h11223344; w_strb = 4'h3; w_valid = 1'b1;
        @(posedge clk); #1; w_valid = 1'b0;
        check("w_first_ready", w_ready, 1'b0);
        check("w_first_bvalid", b_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); aw_addr = 32'h8; aw_valid = 1'b1;
        @(posedge clk); #1; aw_valid = 1'b0;
        check("w_first_bvalid_lat", b_valid, 1'b1);
        check("w_first_reg2", reg_q[64 +: 32], 32'h00003344);
        check("w_first_pulse", wr_pulse, 8'h04);
        @(posedge clk); #1;
        check("w_first_bclr", b_valid, 1'b0);

        // B backpressure with a second write waiting
        @(negedge clk);
        b_ready = 1'b0;
        aw_addr = 32'h8; w_data = 32'hA5A5A5A5; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        @(posedge clk); #1;
        aw_addr = 32'hC; w_data = 32'h00000077;
        check("bp_bvalid", b_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_bvalid", b_valid, 1'b1);
            check("bp_hold_resp", b_resp, 2'b00);
            check("bp_readies", {aw_ready, w_ready}, 2'b00);
        end
        check("bp_reg3_untouched", reg_q[96 +: 32], 32'h0);
        @(negedge clk); b_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_bvalid", b_valid, 1'b0);
        check("bp_release_ready", aw_ready, 1'b1);
        @(posedge clk); #1; aw_valid = 1'b0; w_valid = 1'b0;
        check("bp_second_bvalid", b_valid, 1'b1);
        check("bp_second_reg3", reg_q[96 +: 32], 32'h00000077);
        check("bp_reg2", reg_q[64 +: 32], 32'hA5A5A5A5);
        @(posedge clk); #1;

        // Read colliding with a write commit on reg3
        do_write(32'hC, 32'h5, 4'hF, resp, pulse);
        @(negedge clk);
        aw_addr = 32'hC; w_data = 32'h9; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
        ar_addr = 32'hC; ar_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        check("coll_rvalid", r_valid, 1'b1);
        check("coll_old_data", r_data, 32'h5);
        check("coll_bvalid", b_valid, 1'b1);
        @(posedge clk); #1;
        do_read(32'hC, d, resp);
        check("coll_new_data", d, 32'h9);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
            end else begin
                do_read(vecs[i].addr, d, resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end
        check("final_reg0", reg_q[0 +: 32], 32'h0);
        check("final_reg7", reg_q[224 +: 32], 32'h12340000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
